// File: rtl/mmul_seq.sv
// Sequential single-MAC matrix multiplier: C = A x B on operands captured at start.
// Latency: start accepted at edge t0 -> busy for M*N*K cycles, done pulses in cycle t0+M*N*K+1.
// Backpressure: none; start is ignored while busy or in DONE. Define MMUL_SEQ_SAT_EN for saturating sums.
module mmul_seq #(
    parameter int M     = 2,
    parameter int K     = 2,
    parameter int N     = 2,
    parameter int W     = 32,
    parameter int ACC_W = 2*W + $clog2(K+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [M*K*W-1:0]       A,
    input  logic [K*N*W-1:0]       B,
    output logic [M*N*ACC_W-1:0]   C,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    localparam int IW    = (M > 1) ? $clog2(M) : 1;
    localparam int JW    = (N > 1) ? $clog2(N) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int SUM_W = ((ACC_W > 2*W) ? ACC_W : 2*W) + 1;

    localparam logic [IW-1:0] I_LAST = IW'(M-1);
    localparam logic [JW-1:0] J_LAST = JW'(N-1);
    localparam logic [KW-1:0] K_LAST = KW'(K-1);

    // Degenerate sizes have no meaningful hardware; refuse to elaborate them.
    if (M < 1 || K < 1 || N < 1 || W < 1 || ACC_W < 1) begin : g_bad_params
        $error("mmul_seq: M, K, N, W and ACC_W must all be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [M*K*W-1:0]       a_q, a_d;
    logic [K*N*W-1:0]       b_q, b_d;
    logic [M*N*ACC_W-1:0]   c_q, c_d;
    logic                   ovf_q, ovf_d;

    logic [W-1:0]           a_el, b_el;
    logic [2*W-1:0]         prod;
    logic [SUM_W-1:0]       sum;
    logic                   sum_ovf;
    logic [ACC_W-1:0]       sum_val;
    int                     c_idx;

    // MAC datapath: full-width product, one extra sum bit to catch accumulator overflow.
    always_comb begin
        a_el    = a_q[(int'(i_q)*K + int'(k_q))*W +: W];
        b_el    = b_q[(int'(k_q)*N + int'(j_q))*W +: W];
        prod    = {{W{1'b0}}, a_el} * {{W{1'b0}}, b_el};
        sum     = {{(SUM_W-ACC_W){1'b0}}, acc_q} + {{(SUM_W-2*W){1'b0}}, prod};
        sum_ovf = |sum[SUM_W-1:ACC_W];
`ifdef MMUL_SEQ_SAT_EN
        // Clamp; once clamped, later partial sums overflow again and stay at max.
        sum_val = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        sum_val = sum[ACC_W-1:0];
`endif
        c_idx   = int'(i_q)*N + int'(j_q);
    end

    // Next-state: operand capture in IDLE, i/j/k walk with one MAC per cycle in RUN.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sum_ovf) begin
                    ovf_d = 1'b1;
                end
                if (k_q != K_LAST) begin
                    acc_d = sum_val;
                    k_d   = k_q + 1'b1;
                end else begin
                    c_d[c_idx*ACC_W +: ACC_W] = sum_val;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q != J_LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != I_LAST) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any run and clears C.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign C    = c_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mmul_seq.sv
// Bench for mmul_seq: four instances with different shapes driven by directed and random operands.
// Expected C/ovf come from a per-element accumulation model; latency and handshake checked per run.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_mmul_seq;

    logic clk;
    logic rst_v   [4];
    logic start_v [4];
    logic [255:0] a_v [4];
    logic [255:0] b_v [4];

    logic [79:0]  c0;
    logic [7:0]   c1;
    logic [9:0]   c2;
    logic [101:0] c3;
    logic busy0, busy1, busy2, busy3;
    logic done0, done1, done2, done3;
    logic ovf0, ovf1, ovf2, ovf3;

    int tests = 0;
    int fails = 0;

    mmul_seq #(.M(2), .K(3), .N(2), .W(8), .ACC_W(20)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .A(a_v[0][47:0]), .B(b_v[0][47:0]), .C(c0),
        .busy(busy0), .done(done0), .ovf(ovf0));

    mmul_seq #(.M(1), .K(1), .N(1), .W(8), .ACC_W(8)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .A(a_v[1][7:0]), .B(b_v[1][7:0]), .C(c1),
        .busy(busy1), .done(done1), .ovf(ovf1));

    mmul_seq #(.M(1), .K(4), .N(1), .W(8), .ACC_W(10)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]),
        .A(a_v[2][31:0]), .B(b_v[2][31:0]), .C(c2),
        .busy(busy2), .done(done2), .ovf(ovf2));

    mmul_seq #(.M(3), .K(1), .N(2), .W(8)) u3 (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]),
        .A(a_v[3][23:0]), .B(b_v[3][15:0]), .C(c3),
        .busy(busy3), .done(done3), .ovf(ovf3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void dims(input int u, output int m, output int k, output int n, output int aw);
        case (u)
            0:       begin m = 2; k = 3; n = 2; aw = 20; end
            1:       begin m = 1; k = 1; n = 1; aw = 8;  end
            2:       begin m = 1; k = 4; n = 1; aw = 10; end
            default: begin m = 3; k = 1; n = 2; aw = 17; end
        endcase
    endfunction

    function automatic logic [255:0] get_c(input int u);
        case (u)
            0:       get_c = 256'(c0);
            1:       get_c = 256'(c1);
            2:       get_c = 256'(c2);
            default: get_c = 256'(c3);
        endcase
    endfunction

    function automatic logic get_busy(input int u);
        case (u)
            0: get_busy = busy0;  1: get_busy = busy1;
            2: get_busy = busy2;  default: get_busy = busy3;
        endcase
    endfunction

    function automatic logic get_done(input int u);
        case (u)
            0: get_done = done0;  1: get_done = done1;
            2: get_done = done2;  default: get_done = done3;
        endcase
    endfunction

    function automatic logic get_ovf(input int u);
        case (u)
            0: get_ovf = ovf0;  1: get_ovf = ovf1;
            2: get_ovf = ovf2;  default: get_ovf = ovf3;
        endcase
    endfunction

    // Reference: dot product per element, overflow judged on every running sum.
    function automatic void model(input int u, input logic [255:0] a, input logic [255:0] b,
                                  output logic [255:0] c, output logic ov);
        int m, k, n, aw;
        logic [63:0] s, p, av, bv, maxv;
        dims(u, m, k, n, aw);
        maxv = (64'd1 << aw) - 64'd1;
        c = '0;
        ov = 1'b0;
        for (int r = 0; r < m; r++) begin
            for (int col = 0; col < n; col++) begin
                s = 64'd0;
                for (int x = 0; x < k; x++) begin
                    av = 64'(a[(r*k + x)*8 +: 8]);
                    bv = 64'(b[(x*n + col)*8 +: 8]);
                    p  = av * bv;
                    s  = s + p;
                    if (s > maxv) begin
                        ov = 1'b1;
`ifdef MMUL_SEQ_SAT_EN
                        s = maxv;
`else
                        s = s & maxv;
`endif
                    end
                end
                for (int t = 0; t < aw; t++) begin
                    c[(r*n + col)*aw + t] = s[t];
                end
            end
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run with a start attempt during RUN and during DONE, operands scrambled mid-run.
    task automatic run(input int u, input logic [255:0] a, input logic [255:0] b,
                       output logic [255:0] c_obs, output logic ov_obs);
        int m, k, n, aw, mnk, cyc, bcnt;
        logic [255:0] ce;
        logic oe;
        dims(u, m, k, n, aw);
        mnk = m*n*k;
        model(u, a, b, ce, oe);
        @(negedge clk);
        a_v[u] = a;
        b_v[u] = b;
        start_v[u] = 1'b1;
        @(negedge clk);
        check($sformatf("u%0d_busy_after_start", u), 256'(get_busy(u)), 256'(1));
        check($sformatf("u%0d_c_cleared", u), get_c(u), 256'(0));
        check($sformatf("u%0d_ovf_cleared", u), 256'(get_ovf(u)), 256'(0));
        a_v[u] = rnd256();
        b_v[u] = rnd256();
        cyc = 1;
        bcnt = 0;
        while (get_done(u) !== 1'b1 && cyc < 200) begin
            if (get_busy(u) === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
            start_v[u] = 1'b0;
        end
        check($sformatf("u%0d_done_latency", u), 256'(cyc), 256'(mnk + 1));
        check($sformatf("u%0d_busy_cycles", u), 256'(bcnt), 256'(mnk));
        check($sformatf("u%0d_busy_at_done", u), 256'(get_busy(u)), 256'(0));
        check($sformatf("u%0d_c_result", u), get_c(u), ce);
        check($sformatf("u%0d_ovf_result", u), 256'(get_ovf(u)), 256'(oe));
        c_obs  = get_c(u);
        ov_obs = get_ovf(u);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        check($sformatf("u%0d_done_one_cycle", u), 256'(get_done(u)), 256'(0));
        check($sformatf("u%0d_start_in_done_ignored", u), 256'(get_busy(u)), 256'(0));
        check($sformatf("u%0d_c_hold", u), get_c(u), ce);
    endtask

    initial begin
        logic [255:0] cv, ce, ra, rb;
        logic ov, oe;

        for (int u = 0; u < 4; u++) begin
            rst_v[u] = 1'b1;
            start_v[u] = 1'b0;
            a_v[u] = '0;
            b_v[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("u%0d_rst_c", u), get_c(u), 256'(0));
            check($sformatf("u%0d_rst_busy", u), 256'(get_busy(u)), 256'(0));
            check($sformatf("u%0d_rst_done", u), 256'(get_done(u)), 256'(0));
            check($sformatf("u%0d_rst_ovf", u), 256'(get_ovf(u)), 256'(0));
            rst_v[u] = 1'b0;
        end

        // 2x3x2 directed product
        run(0, 256'({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}),
               256'({8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7}), cv, ov);
        check("u0_directed_c", cv, 256'({20'd154, 20'd139, 20'd64, 20'd58}));
        check("u0_directed_ovf", 256'(ov), 256'(0));
        for (int r = 0; r < 3; r++) begin
            run(0, rnd256(), rnd256(), cv, ov);
        end

        // Reset in the middle of a 2x3x2 run after the first C element landed
        ra = rnd256();
        rb = rnd256();
        model(0, ra, rb, ce, oe);
        @(negedge clk);
        a_v[0] = ra;
        b_v[0] = rb;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        cv = get_c(0);
        check("u0_partial_c00", 256'(cv[19:0]), 256'(ce[19:0]));
        check("u0_unwritten_zero", 256'(cv[79:20]), 256'(0));
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("u0_midrun_rst_c", get_c(0), 256'(0));
        check("u0_midrun_rst_busy", 256'(get_busy(0)), 256'(0));
        check("u0_midrun_rst_done", 256'(get_done(0)), 256'(0));
        check("u0_midrun_rst_ovf", 256'(get_ovf(0)), 256'(0));
        @(negedge clk);
        check("u0_idle_after_rst", 256'(get_busy(0)), 256'(0));
        run(0, rnd256(), rnd256(), cv, ov);

        // 1x1x1, 16*16 overflows an 8-bit accumulator
        run(1, 256'(16), 256'(16), cv, ov);
`ifdef MMUL_SEQ_SAT_EN
        check("u1_16x16_c", cv, 256'(255));
`else
        check("u1_16x16_c", cv, 256'(0));
`endif
        check("u1_16x16_ovf", 256'(ov), 256'(1));
        for (int r = 0; r < 3; r++) begin
            run(1, rnd256(), rnd256(), cv, ov);
        end

        // 1x4x1, all 255 -> 260100 into 10 bits
        run(2, 256'(32'hFFFF_FFFF), 256'(32'hFFFF_FFFF), cv, ov);
`ifdef MMUL_SEQ_SAT_EN
        check("u2_all255_c", cv, 256'(1023));
`else
        check("u2_all255_c", cv, 256'(4));
`endif
        check("u2_all255_ovf", 256'(ov), 256'(1));
        for (int r = 0; r < 4; r++) begin
            run(2, rnd256(), rnd256(), cv, ov);
        end

        // 3x1x2, one C write per cycle, default accumulator width (17)
        run(3, 256'({8'd3, 8'd2, 8'd1}), 256'({8'd5, 8'd4}), cv, ov);
        check("u3_directed_c", cv, 256'({17'd15, 17'd12, 17'd10, 17'd8, 17'd5, 17'd4}));
        for (int r = 0; r < 3; r++) begin
            run(3, rnd256(), rnd256(), cv, ov);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
